hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//  Pipeline hazard controller: drives flush/stall into the IF/ID and ID/EX
//  pipeline registers and the PC. Detects load-use hazards (ID vs EX),
//  sequences multi-cycle flushes after taken branches/jumps resolved in EX,
//  and freezes the pipe while data memory is busy. Keeps a stall-cycle counter.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register-file address width
//  FLUSH_CYCLES    1   cycles of IF/ID+ID/EX flush per redirect (1..7)
//  CNT_WIDTH       16  width of stall/flush event counter
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async active-low reset
//  id_rd_addr1_in   in   RAW ID-stage source register 1
//  id_rd_addr2_in   in   RAW ID-stage source register 2
//  id_uses_rs2_in   in   1   ID instruction reads rs2 (0 for immediate forms)
//  ex_mem_rd_en_in  in   1   instruction in EX is a load (ID/EX mem_data_rd_en_out)
//  ex_wr_addr_in    in   RAW EX destination register
//  ex_wr_en_in      in   1   EX instruction writes the register file
//  ex_redirect_in   in   1   EX resolved taken branch or jump
//  mem_busy_in      in   1   data memory not ready; whole pipe must freeze
//  pc_stall_out     out  1   hold PC
//  if_id_stall_out  out  1   hold IF/ID
//  if_id_flush_out  out  1   clear IF/ID
//  id_ex_stall_out  out  1   hold ID/EX
//  id_ex_flush_out  out  1   clear ID/EX (drives flush_in of ID/EX)
//  stall_cnt_out    out  CNT_WIDTH  saturating count of non-RUN-issue cycles
//  (RAW = REG_ADDR_WIDTH)
// BEHAVIOUR
//  Reset: state=RUN, flush counter=0, stall_cnt_out=0; while rst_n=0 every
//   stall/flush output is 0 regardless of inputs.
//  Outputs: combinational from registered state + current inputs (0 latency).
//  load_use = ex_mem_rd_en_in & ex_wr_en_in & ex_wr_addr_in!=0 &
//   (ex_wr_addr_in==id_rd_addr1_in | (id_uses_rs2_in & ex_wr_addr_in==id_rd_addr2_in)).
//  Per-cycle priority (highest first):
//   1 mem_busy_in: pc/if_id/id_ex stall=1, all flush=0; state and counter hold.
//   2 ex_redirect_in: if_id_flush=1, id_ex_flush=1, stalls=0; load
//     cnt=FLUSH_CYCLES-1; next=FLUSH if cnt>0 else RUN. Redirect in FLUSH reloads.
//   3 state FLUSH: if_id_flush=1, id_ex_flush=1; cnt-=1; cnt reaching 0 -> RUN.
//   4 load_use (RUN only): pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble);
//     no state change -- next cycle load is in MEM so hazard clears naturally.
//   5 otherwise all outputs 0.
//  Redirect beats load_use: ID instruction is wrong-path, stalling it is wrong.
//  stall_cnt_out += 1 in any cycle where any stall or flush output is 1;
//   saturates at all-ones (no wrap). Not incremented while rst_n=0.
//  Never assert stall and flush of the same register in one cycle.
//  Reset mid-FLUSH: outputs drop to 0 immediately, FSM returns to RUN.
//  FLUSH_CYCLES outside 1..7: elaboration error via generate check.
// STRUCTURE
//  Shared package/include: state encodings (ST_RUN, ST_FLUSH), REG_ADDR_WIDTH
//   default shared with the pipeline registers and register file.
//  Single module; no sub-module (compare logic + 2-state FSM + counter).
// TESTING
//  T1 load r3; next ID add r4,r3,r1 -> 1 cycle pc_stall=if_id_stall=id_ex_flush=1, then 0.
//  T2 load r0 to ID reading r0 / id_uses_rs2=0 with rs2 match -> no stall asserted.
//  T3 FLUSH_CYCLES=3, ex_redirect pulse -> if_id_flush=id_ex_flush=1 for exactly 3 cycles.
//  T4 ex_redirect and load_use same cycle -> flushes=1, pc_stall=0, if_id_stall=0.
//  T5 mem_busy 4 cycles mid-FLUSH (cnt=1) -> all stalls 1 for 4 cycles, then 1 flush cycle.
//  T6 rst_n low during FLUSH -> outputs 0 same cycle, stall_cnt_out=0; CNT_WIDTH=4 saturates at 15.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared definitions for the hazard/flush controller and the pipeline
// blocks around it.
//   DEF_REG_ADDR_WIDTH : register-file address width used by the pipeline
//                        registers, the register file and this controller
//   ST_RUN / ST_FLUSH  : encodings of the controller's two-state FSM
package hazard_flush_ctrl_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 5;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller. Generates stall/flush controls for the PC,
// the IF/ID and ID/EX pipeline registers, based on load-use hazards,
// taken branches/jumps resolved in EX and data-memory back-pressure.
// Also keeps a saturating count of cycles in which any control was active.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_rd_addr1_in    ID source register 1
//   id_rd_addr2_in    ID source register 2
//   id_uses_rs2_in    ID instruction actually reads rs2
//   ex_mem_rd_en_in   EX instruction is a load
//   ex_wr_addr_in     EX destination register
//   ex_wr_en_in       EX instruction writes the register file
//   ex_redirect_in    EX resolved a taken branch or jump
//   mem_busy_in       data memory not ready, freeze the whole pipe
//   pc_stall_out      hold PC
//   if_id_stall_out   hold IF/ID
//   if_id_flush_out   clear IF/ID
//   id_ex_stall_out   hold ID/EX
//   id_ex_flush_out   clear ID/EX
//   stall_cnt_out     saturating count of cycles with any stall/flush active
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2_in,
    input  logic                      id_uses_rs2_in,
    input  logic                      ex_mem_rd_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_in,
    input  logic                      ex_wr_en_in,
    input  logic                      ex_redirect_in,
    input  logic                      mem_busy_in,
    output logic                      pc_stall_out,
    output logic                      if_id_stall_out,
    output logic                      if_id_flush_out,
    output logic                      id_ex_stall_out,
    output logic                      id_ex_flush_out,
    output logic [CNT_WIDTH-1:0]      stall_cnt_out
);

    // The flush counter is 3 bits wide, so only 1..7 flush cycles are legal.
    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
            $error("hazard_flush_ctrl: FLUSH_CYCLES must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0] state, next_state;
    logic [2:0] flush_cnt, next_flush_cnt;

    logic load_use;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic any_active;

    // r0 is hard-wired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_mem_rd_en_in && ex_wr_en_in &&
                      (ex_wr_addr_in != '0) &&
                      ((ex_wr_addr_in == id_rd_addr1_in) ||
                       (id_uses_rs2_in && (ex_wr_addr_in == id_rd_addr2_in)));

    // Priority: memory freeze, then redirect (the ID instruction is on the
    // wrong path so it must be flushed, not stalled), then an ongoing
    // multi-cycle flush, then a load-use bubble.
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        next_state     = state;
        next_flush_cnt = flush_cnt;

        if (mem_busy_in) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (ex_redirect_in) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            next_flush_cnt = FLUSH_RELOAD;
            next_state     = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (state == ST_FLUSH) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            next_flush_cnt = flush_cnt - 3'd1;
            next_state     = (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (load_use) begin
            // One bubble is enough: next cycle the load reaches MEM and the
            // hazard disappears without any state change.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Gate the controls with rst_n so they drop in the same cycle reset
    // asserts, independent of the input pins.
    assign pc_stall_out    = pc_stall    & rst_n;
    assign if_id_stall_out = if_id_stall & rst_n;
    assign if_id_flush_out = if_id_flush & rst_n;
    assign id_ex_stall_out = id_ex_stall & rst_n;
    assign id_ex_flush_out = id_ex_flush & rst_n;

    assign any_active = pc_stall | if_id_stall | if_id_flush |
                        id_ex_stall | id_ex_flush;

    // FSM state and remaining flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
        end
    end

    // Saturating event counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_out <= '0;
        end else if (any_active && (stall_cnt_out != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_out <= stall_cnt_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed testbench for hazard_flush_ctrl, built with FLUSH_CYCLES=3 and
// CNT_WIDTH=4 so both multi-cycle flush and counter saturation are reachable.
module tb_hazard_flush_ctrl;

    localparam int RAW = 5;
    localparam int FC  = 3;
    localparam int CW  = 4;

    localparam logic [4:0] OUT_IDLE  = 5'b00000;
    localparam logic [4:0] OUT_LU    = 5'b11001;
    localparam logic [4:0] OUT_FLUSH = 5'b00101;
    localparam logic [4:0] OUT_BUSY  = 5'b11010;

    logic           clk;
    logic           rst_n;
    logic [RAW-1:0] id_rd_addr1;
    logic [RAW-1:0] id_rd_addr2;
    logic           id_uses_rs2;
    logic           ex_mem_rd_en;
    logic [RAW-1:0] ex_wr_addr;
    logic           ex_wr_en;
    logic           ex_redirect;
    logic           mem_busy;
    logic           pc_stall;
    logic           if_id_stall;
    logic           if_id_flush;
    logic           id_ex_stall;
    logic           id_ex_flush;
    logic [CW-1:0]  stall_cnt;
    logic [4:0]     obs;

    int n_checks;
    int n_fail;

    // Observed control vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}
    assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush};

    hazard_flush_ctrl #(
        .REG_ADDR_WIDTH (RAW),
        .FLUSH_CYCLES   (FC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rd_addr1_in  (id_rd_addr1),
        .id_rd_addr2_in  (id_rd_addr2),
        .id_uses_rs2_in  (id_uses_rs2),
        .ex_mem_rd_en_in (ex_mem_rd_en),
        .ex_wr_addr_in   (ex_wr_addr),
        .ex_wr_en_in     (ex_wr_en),
        .ex_redirect_in  (ex_redirect),
        .mem_busy_in     (mem_busy),
        .pc_stall_out    (pc_stall),
        .if_id_stall_out (if_id_stall),
        .if_id_flush_out (if_id_flush),
        .id_ex_stall_out (id_ex_stall),
        .id_ex_flush_out (id_ex_flush),
        .stall_cnt_out   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge; outputs settle 1ns later,
    // well before the next rising edge commits state.
    task automatic drive(input logic [RAW-1:0] r1, input logic [RAW-1:0] r2,
                         input logic u2, input logic ld, input logic [RAW-1:0] wa,
                         input logic we, input logic rd, input logic busy);
        @(negedge clk);
        id_rd_addr1  = r1;
        id_rd_addr2  = r2;
        id_uses_rs2  = u2;
        ex_mem_rd_en = ld;
        ex_wr_addr   = wa;
        ex_wr_en     = we;
        ex_redirect  = rd;
        mem_busy     = busy;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        // Inputs that would normally force stalls/flushes.
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, OUT_IDLE);
        end
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_count: got %0d expected 0", stall_cnt);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        // lw r3 in EX, add r4,r3,r1 in ID
        drive(5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_LU) begin
            n_fail++;
            $display("[TB] FAIL load_use_rs1: got %b expected %b", obs, OUT_LU);
        end
        // Bubble now in EX, hazard gone
        drive(5'd3, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL load_use_clear: got %b expected %b", obs, OUT_IDLE);
        end
        // Match on rs2 with rs2 in use
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_LU) begin
            n_fail++;
            $display("[TB] FAIL load_use_rs2: got %b expected %b", obs, OUT_LU);
        end
        idle();
        n_checks++;
        if (stall_cnt !== 4'd2) begin
            n_fail++;
            $display("[TB] FAIL load_use_count: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        // Load to r0 read by ID
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL no_hazard_r0: got %b expected %b", obs, OUT_IDLE);
        end
        // rs2 matches but immediate form
        drive(5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL no_hazard_imm: got %b expected %b", obs, OUT_IDLE);
        end
        // Matching ALU instruction (not a load)
        drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL no_hazard_alu: got %b expected %b", obs, OUT_IDLE);
        end
        // Load without register write-enable
        drive(5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL no_hazard_nowe: got %b expected %b", obs, OUT_IDLE);
        end
        idle();
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL no_hazard_count: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== OUT_FLUSH) begin
            n_fail++;
            $display("[TB] FAIL redirect_c0: got %b expected %b", obs, OUT_FLUSH);
        end
        for (int i = 1; i < 3; i++) begin
            idle();
            n_checks++;
            if (obs !== OUT_FLUSH) begin
                n_fail++;
                $display("[TB] FAIL redirect_c%0d: got %b expected %b", i, obs, OUT_FLUSH);
            end
        end
        idle();
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL redirect_end: got %b expected %b", obs, OUT_IDLE);
        end
        n_checks++;
        if (stall_cnt !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL redirect_count: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_redirect_vs_load_use();
        do_reset();
        drive(5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== OUT_FLUSH) begin
            n_fail++;
            $display("[TB] FAIL redir_lu_prio: got %b expected %b", obs, OUT_FLUSH);
        end
        // Load-use pattern still present during FLUSH: flush must win
        drive(5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== OUT_FLUSH) begin
            n_fail++;
            $display("[TB] FAIL redir_lu_flush: got %b expected %b", obs, OUT_FLUSH);
        end
        idle();
        idle();
        n_checks++;
        if (obs !== OUT_IDLE || stall_cnt !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL redir_lu_end: got %b cnt %0d expected %b cnt 3",
                     obs, stall_cnt, OUT_IDLE);
        end
    endtask

    task automatic test_mem_busy_mid_flush();
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        // Now in FLUSH with one flush cycle left
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs !== OUT_BUSY) begin
                n_fail++;
                $display("[TB] FAIL busy_c%0d: got %b expected %b", i, obs, OUT_BUSY);
            end
        end
        idle();
        n_checks++;
        if (obs !== OUT_FLUSH) begin
            n_fail++;
            $display("[TB] FAIL busy_resume_flush: got %b expected %b", obs, OUT_FLUSH);
        end
        idle();
        n_checks++;
        if (obs !== OUT_IDLE || stall_cnt !== 4'd7) begin
            n_fail++;
            $display("[TB] FAIL busy_end: got %b cnt %0d expected %b cnt 7",
                     obs, stall_cnt, OUT_IDLE);
        end
        // Busy beats a load-use hazard in RUN
        drive(5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== OUT_BUSY) begin
            n_fail++;
            $display("[TB] FAIL busy_vs_lu: got %b expected %b", obs, OUT_BUSY);
        end
        idle();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        // Assert reset while FLUSH is active
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== OUT_IDLE || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_flush: got %b cnt %0d expected %b cnt 0",
                     obs, stall_cnt, OUT_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        n_checks++;
        if (obs !== OUT_IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_back_to_run: got %b expected %b", obs, OUT_IDLE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        end
        idle();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("[TB] FAIL sat_count: got %0d expected 15", stall_cnt);
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("[TB] FAIL sat_no_wrap: got %0d expected 15", stall_cnt);
        end
        idle();
        idle();
    endtask

    // Flags any cycle where a register is both stalled and flushed.
    always @(negedge clk) begin
        #2;
        if (rst_n && ((if_id_stall && if_id_flush) || (id_ex_stall && id_ex_flush))) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL stall_flush_overlap: got %b", obs);
        end
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        id_rd_addr1  = '0;
        id_rd_addr2  = '0;
        id_uses_rs2  = 1'b0;
        ex_mem_rd_en = 1'b0;
        ex_wr_addr   = '0;
        ex_wr_en     = 1'b0;
        ex_redirect  = 1'b0;
        mem_busy     = 1'b0;

        $display("[TB] starting hazard_flush_ctrl tests");
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_redirect_vs_load_use();
        test_mem_busy_mid_flush();
        test_reset_mid_flush();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
